// File: rtl/ahbl_splitter_burst_if.sv
// AHB-lite bus bundle for ahbl_splitter_burst: one master-side port and N_PORTS slave-side ports.
// The slave modport is the splitter's view; master is the view of whatever drives it.
interface ahbl_splitter_burst_if #(
  parameter int N_PORTS = 4,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
);
  logic                            src_hready;
  logic                            src_hready_resp;
  logic                            src_hresp;
  logic [W_ADDR-1:0]               src_haddr;
  logic                            src_hwrite;
  logic [1:0]                      src_htrans;
  logic [2:0]                      src_hsize;
  logic [2:0]                      src_hburst;
  logic [3:0]                      src_hprot;
  logic                            src_hmastlock;
  logic [W_DATA-1:0]               src_hwdata;
  logic [W_DATA-1:0]               src_hrdata;

  logic [N_PORTS-1:0]              dst_hready;
  logic [N_PORTS-1:0]              dst_hready_resp;
  logic [N_PORTS-1:0]              dst_hresp;
  logic [N_PORTS-1:0][W_ADDR-1:0]  dst_haddr;
  logic [N_PORTS-1:0]              dst_hwrite;
  logic [N_PORTS-1:0][1:0]         dst_htrans;
  logic [N_PORTS-1:0][2:0]         dst_hsize;
  logic [N_PORTS-1:0][2:0]         dst_hburst;
  logic [N_PORTS-1:0][3:0]         dst_hprot;
  logic [N_PORTS-1:0]              dst_hmastlock;
  logic [N_PORTS-1:0][W_DATA-1:0]  dst_hwdata;
  logic [N_PORTS-1:0][W_DATA-1:0]  dst_hrdata;

  modport slave (
    input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
           src_hprot, src_hmastlock, src_hwdata,
    output src_hready_resp, src_hresp, src_hrdata,
    output dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
           dst_hprot, dst_hmastlock, dst_hwdata,
    input  dst_hready_resp, dst_hresp, dst_hrdata
  );

  modport master (
    output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
           src_hprot, src_hmastlock, src_hwdata,
    input  src_hready_resp, src_hresp, src_hrdata,
    input  dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
           dst_hprot, dst_hmastlock, dst_hwdata,
    output dst_hready_resp, dst_hresp, dst_hrdata
  );
endinterface

// File: rtl/ahbl_splitter_burst.sv
// AHB-lite 1:N splitter with burst-locked routing, lowest-index window priority and a two-cycle decode error.
// Define AHBL_SPLITTER_ERR_CAPTURE_EN to record the address of the first decode error in err_addr/err_valid.

module ahbl_splitter_burst_lane #(
  parameter int W_ADDR = 32
) (
  input  logic [W_ADDR-1:0] haddr,
  input  logic [W_ADDR-1:0] map,
  input  logic [W_ADDR-1:0] mask,
  input  logic              conn,
  input  logic              route,
  input  logic [1:0]        htrans,
  output logic              match,
  output logic [1:0]        dst_htrans
);
  assign match      = conn & ((haddr & mask) == map);
  assign dst_htrans = route ? htrans : 2'b00;
endmodule

module ahbl_splitter_burst #(
  parameter int                          N_PORTS   = 4,
  parameter int                          W_ADDR    = 32,
  parameter int                          W_DATA    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MAP  = '0,
  parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MASK = '0,
  parameter logic [N_PORTS-1:0]          CONN_MASK = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  ahbl_splitter_burst_if.slave bus,
  input  logic               err_clr,
  output logic [W_ADDR-1:0]  err_addr,
  output logic               err_valid
);
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  typedef enum logic [1:0] {D_IDLE, D_SLV, D_ERR1, D_ERR2} dstate_t;

  dstate_t            state, state_nx;
  logic [N_PORTS-1:0] match, dec_oh, sel_a;
  logic [N_PORTS-1:0] burst_sel, burst_nx, sel_d, sel_d_nx;
  logic               dec_err, err_entry;
  logic               hready_resp, hresp;
  logic [W_DATA-1:0]  hrdata;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_lane
    ahbl_splitter_burst_lane #(.W_ADDR(W_ADDR)) u_lane (
      .haddr      (bus.src_haddr),
      .map        (ADDR_MAP[i*W_ADDR +: W_ADDR]),
      .mask       (ADDR_MASK[i*W_ADDR +: W_ADDR]),
      .conn       (CONN_MASK[i]),
      .route      (sel_a[i]),
      .htrans     (bus.src_htrans),
      .match      (match[i]),
      .dst_htrans (bus.dst_htrans[i])
    );
  end

  assign bus.dst_hready    = {N_PORTS{bus.src_hready}};
  assign bus.dst_haddr     = {N_PORTS{bus.src_haddr}};
  assign bus.dst_hwrite    = {N_PORTS{bus.src_hwrite}};
  assign bus.dst_hsize     = {N_PORTS{bus.src_hsize}};
  assign bus.dst_hburst    = {N_PORTS{bus.src_hburst}};
  assign bus.dst_hprot     = {N_PORTS{bus.src_hprot}};
  assign bus.dst_hmastlock = {N_PORTS{bus.src_hmastlock}};
  assign bus.dst_hwdata    = {N_PORTS{bus.src_hwdata}};

  // SEQ/BUSY never re-decode: they follow the port locked by the burst's NONSEQ.
  always_comb begin
    dec_oh  = '0;
    for (int i = N_PORTS-1; i >= 0; i--)
      if (match[i]) begin
        dec_oh    = '0;
        dec_oh[i] = 1'b1;
      end
    sel_a   = '0;
    dec_err = 1'b0;
    case (bus.src_htrans)
      HT_IDLE:   ;
      HT_NONSEQ: begin
        sel_a   = dec_oh;
        dec_err = ~|match;
      end
      default: begin
        sel_a   = burst_sel;
        dec_err = ~|burst_sel;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= D_IDLE;
      sel_d     <= '0;
      burst_sel <= '0;
    end else begin
      state     <= state_nx;
      sel_d     <= sel_d_nx;
      burst_sel <= burst_nx;
    end
  end

  // Response depends only on registered data-phase state, never on the current address phase.
  always_comb begin
    state_nx    = state;
    sel_d_nx    = sel_d;
    burst_nx    = burst_sel;
    err_entry   = 1'b0;
    hready_resp = 1'b1;
    hresp       = 1'b0;
    hrdata      = '0;
    case (state)
      D_SLV: begin
        hready_resp = |(bus.dst_hready_resp & sel_d);
        hresp       = |(bus.dst_hresp & sel_d);
        for (int i = 0; i < N_PORTS; i++)
          hrdata = hrdata | (bus.dst_hrdata[i] & {W_DATA{sel_d[i]}});
      end
      D_ERR1: begin
        hready_resp = 1'b0;
        hresp       = 1'b1;
        state_nx    = D_ERR2;
      end
      D_ERR2: hresp = 1'b1;
      default: ;
    endcase
    if (state != D_ERR1 && bus.src_hready) begin
      if (bus.src_htrans == HT_IDLE)   burst_nx = '0;
      if (bus.src_htrans == HT_NONSEQ) burst_nx = dec_oh;
      if (dec_err) begin
        state_nx  = D_ERR1;
        sel_d_nx  = '0;
        err_entry = 1'b1;
      end else if (|sel_a) begin
        state_nx  = D_SLV;
        sel_d_nx  = sel_a;
      end else begin
        state_nx  = D_IDLE;
        sel_d_nx  = '0;
      end
    end
  end

  assign bus.src_hready_resp = hready_resp;
  assign bus.src_hresp       = hresp;
  assign bus.src_hrdata      = hrdata;

`ifdef AHBL_SPLITTER_ERR_CAPTURE_EN
  // First error sticks until cleared; a capture outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (err_entry && !err_valid) begin
      err_valid <= 1'b1;
      err_addr  <= bus.src_haddr;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end
`else
  logic unused_err;
  assign unused_err = err_clr ^ err_entry;
  assign err_addr   = '0;
  assign err_valid  = 1'b0;
`endif
endmodule

// File: tb/tb_ahbl_splitter_burst.sv
// Directed and randomized checks of ahbl_splitter_burst against a transaction-level reference model.
module tb_ahbl_splitter_burst;
  localparam int N = 4, WA = 32, WD = 32;
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [N*WA-1:0] MAP     = {32'h6000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [N*WA-1:0] MAP_OVL = {32'h6000_0000, 32'h2000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [N*WA-1:0] MASK    = {4{32'hE000_0000}};

  logic clk = 1'b0, rst_n = 1'b0, err_clr = 1'b0;
  logic [WA-1:0] err_addr, err_addr_o, err_addr_c;
  logic err_valid, err_valid_o, err_valid_c;
  always #5 clk = ~clk;

  ahbl_splitter_burst_if #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) bus ();
  ahbl_splitter_burst_if #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) bus_o ();
  ahbl_splitter_burst_if #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) bus_c ();

  assign bus.src_hready   = bus.src_hready_resp;
  assign bus_o.src_hready = bus_o.src_hready_resp;
  assign bus_c.src_hready = bus_c.src_hready_resp;
  assign bus_o.src_haddr = bus.src_haddr;   assign bus_c.src_haddr = bus.src_haddr;
  assign bus_o.src_htrans = bus.src_htrans; assign bus_c.src_htrans = bus.src_htrans;
  assign bus_o.src_hwrite = bus.src_hwrite; assign bus_c.src_hwrite = bus.src_hwrite;
  assign bus_o.src_hsize = bus.src_hsize;   assign bus_c.src_hsize = bus.src_hsize;
  assign bus_o.src_hburst = bus.src_hburst; assign bus_c.src_hburst = bus.src_hburst;
  assign bus_o.src_hprot = bus.src_hprot;   assign bus_c.src_hprot = bus.src_hprot;
  assign bus_o.src_hmastlock = bus.src_hmastlock; assign bus_c.src_hmastlock = bus.src_hmastlock;
  assign bus_o.src_hwdata = bus.src_hwdata; assign bus_c.src_hwdata = bus.src_hwdata;
  assign bus_o.dst_hready_resp = '1; assign bus_c.dst_hready_resp = '1;
  assign bus_o.dst_hresp = '0;       assign bus_c.dst_hresp = '0;
  assign bus_o.dst_hrdata = '0;      assign bus_c.dst_hrdata = '0;

  ahbl_splitter_burst #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD), .ADDR_MAP(MAP), .ADDR_MASK(MASK),
    .CONN_MASK(4'b1111)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus), .err_clr(err_clr),
    .err_addr(err_addr), .err_valid(err_valid));
  ahbl_splitter_burst #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD), .ADDR_MAP(MAP_OVL), .ADDR_MASK(MASK),
    .CONN_MASK(4'b1111)) u_ovl (.clk(clk), .rst_n(rst_n), .bus(bus_o), .err_clr(err_clr),
    .err_addr(err_addr_o), .err_valid(err_valid_o));
  ahbl_splitter_burst #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD), .ADDR_MAP(MAP_OVL), .ADDR_MASK(MASK),
    .CONN_MASK(4'b1101)) u_conn (.clk(clk), .rst_n(rst_n), .bus(bus_c), .err_clr(err_clr),
    .err_addr(err_addr_c), .err_valid(err_valid_c));

  int n_cmp = 0, n_mis = 0;
  // Reference model: who owns the data phase, and which port the current burst is pinned to.
  int dp_port = -1, dp_err = 0, burst_port = -1, rt = -1;
  logic cap_valid = 1'b0, exp_rdy = 1'b1, rt_err = 1'b0, chk_en = 1'b0;
  logic [31:0] cap_addr = '0, cur_a = '0;
  logic [1:0] cur_tr = IDLE;
  logic [3:0] drv_rdy = '1, drv_resp = '0;
  logic [N-1:0][WD-1:0] drv_rd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & MASK[i*WA +: WA]) == MAP[i*WA +: WA]) return i;
    return -1;
  endfunction

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic [3:0] rdy,
                       input logic [3:0] resp, input logic clr);
    cur_tr = tr; cur_a = a; drv_rdy = rdy; drv_resp = resp;
    for (int i = 0; i < N; i++) drv_rd[i] = $urandom;
    bus.src_htrans = tr; bus.src_haddr = a; bus.src_hwrite = 1'($urandom_range(0, 1));
    bus.src_hsize = 3'd2; bus.src_hburst = 3'd1; bus.src_hprot = 4'h3; bus.src_hmastlock = 1'b0;
    bus.src_hwdata = $urandom;
    bus.dst_hready_resp = rdy; bus.dst_hresp = resp; bus.dst_hrdata = drv_rd;
    err_clr = clr;
  endtask

  task automatic settle_check();
    logic exp_resp;
    logic [31:0] exp_rd;
    logic [N-1:0][1:0] exp_ht;
    @(negedge clk);
    if (dp_err == 1)      begin exp_rdy = 1'b0; exp_resp = 1'b1; exp_rd = '0; end
    else if (dp_err == 2) begin exp_rdy = 1'b1; exp_resp = 1'b1; exp_rd = '0; end
    else if (dp_port >= 0) begin
      exp_rdy = drv_rdy[dp_port]; exp_resp = drv_resp[dp_port]; exp_rd = drv_rd[dp_port];
    end else begin exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = '0; end
    rt = -1; rt_err = 1'b0;
    if (cur_tr == NONSEQ)    begin rt = decode(cur_a); rt_err = (rt < 0); end
    else if (cur_tr != IDLE) begin rt = burst_port;    rt_err = (rt < 0); end
    exp_ht = '0;
    if (rt >= 0) exp_ht[rt] = cur_tr;
    if (chk_en) begin
      chk("hready_resp", 64'(bus.src_hready_resp), 64'(exp_rdy));
      chk("hresp", 64'(bus.src_hresp), 64'(exp_resp));
      chk("hrdata", 64'(bus.src_hrdata), 64'(exp_rd));
      chk("dst_htrans", 64'(bus.dst_htrans), 64'(exp_ht));
      chk("dst_hready", 64'(bus.dst_hready), 64'({N{exp_rdy}}));
      chk("dst_haddr3", 64'(bus.dst_haddr[3]), 64'(cur_a));
      chk("err_valid", 64'(err_valid), 64'(cap_valid));
      chk("err_addr", 64'(err_addr), 64'(cap_addr));
    end
  endtask

  task automatic tick();
    logic entering;
    @(posedge clk);
    entering = rst_n && dp_err != 1 && exp_rdy && rt_err;
    if (!rst_n) begin
      dp_port = -1; dp_err = 0; burst_port = -1; cap_valid = 1'b0; cap_addr = '0;
    end else begin
`ifdef AHBL_SPLITTER_ERR_CAPTURE_EN
      if (entering && !cap_valid) begin cap_valid = 1'b1; cap_addr = cur_a; end
      else if (err_clr) cap_valid = 1'b0;
`endif
      if (dp_err == 1) dp_err = 2;
      else if (exp_rdy) begin
        if (cur_tr == IDLE) burst_port = -1;
        else if (cur_tr == NONSEQ) burst_port = rt;
        if (entering) begin dp_err = 1; dp_port = -1; end
        else begin dp_err = 0; dp_port = rt; end
      end
    end
    #1;
  endtask

  task automatic step(input logic [1:0] tr, input logic [31:0] a, input logic [3:0] rdy,
                      input logic [3:0] resp, input logic clr);
    drive(tr, a, rdy, resp, clr); settle_check(); tick();
  endtask

  initial begin
    int beats, r;
    logic acc;
    logic [1:0] tr;
    logic [31:0] a;
    logic [3:0] rdyv, respv;

    drive(IDLE, 32'h0, 4'hF, 4'h0, 1'b0);
    rst_n = 1'b0;
    settle_check(); tick(); settle_check(); tick();
    rst_n = 1'b1; chk_en = 1'b1;

    drive(IDLE, 32'h0, 4'hF, 4'h0, 1'b0); settle_check();
    chk("rst_hready_resp", 64'(bus.src_hready_resp), 64'h1);
    chk("rst_hresp", 64'(bus.src_hresp), 64'h0);
    chk("rst_hrdata", 64'(bus.src_hrdata), 64'h0);
    chk("rst_err_valid", 64'(err_valid), 64'h0);
    tick();

    // Port-1 read; overlap copies prefer port 1 unless it is disconnected.
    drive(NONSEQ, 32'h2000_0010, 4'hF, 4'h0, 1'b0); settle_check();
    chk("dec_p1_htrans", 64'(bus.dst_htrans), 64'h08);
    chk("ovl_htrans", 64'(bus_o.dst_htrans), 64'h08);
    chk("conn_htrans", 64'(bus_c.dst_htrans), 64'h20);
    tick();
    drive(IDLE, 32'h0, 4'hF, 4'h0, 1'b0); settle_check();
    chk("p1_rdata", 64'(bus.src_hrdata), 64'(drv_rd[1]));
    tick();

    drive(NONSEQ, 32'h9000_0000, 4'hF, 4'h0, 1'b0); settle_check();
    chk("err_no_route", 64'(bus.dst_htrans), 64'h00);
    tick();
    drive(IDLE, 32'h0, 4'hF, 4'h0, 1'b0); settle_check();
    chk("err1_rdy", 64'(bus.src_hready_resp), 64'h0);
    chk("err1_resp", 64'(bus.src_hresp), 64'h1);
`ifdef AHBL_SPLITTER_ERR_CAPTURE_EN
    chk("cap_addr", 64'(err_addr), 64'h9000_0000);
    chk("cap_valid", 64'(err_valid), 64'h1);
`endif
    tick();
    drive(IDLE, 32'h0, 4'hF, 4'h0, 1'b0); settle_check();
    chk("err2_rdy", 64'(bus.src_hready_resp), 64'h1);
    chk("err2_resp", 64'(bus.src_hresp), 64'h1);
    tick();
    step(IDLE, 32'h0, 4'hF, 4'h0, 1'b1);

    // INCR4 crossing into port 1's window stays pinned to port 0.
    for (int i = 0; i < 4; i++) begin
      drive(i == 0 ? NONSEQ : SEQ, 32'h1FFF_FFF8 + 32'(4 * i), 4'hF, 4'h0, 1'b0); settle_check();
      chk("incr4_htrans", 64'(bus.dst_htrans), (i == 0) ? 64'h02 : 64'h03);
      chk("incr4_hresp", 64'(bus.src_hresp), 64'h0);
      tick();
    end
    step(IDLE, 32'h0, 4'hF, 4'h0, 1'b0);

    step(NONSEQ, 32'h6000_0040, 4'hF, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(IDLE, 32'h0, 4'b0111, 4'h0, 1'b0); settle_check();
      chk("stall_rdy", 64'(bus.src_hready_resp), 64'h0);
      chk("stall_dst_hready", 64'(bus.dst_hready), 64'h0);
      chk("stall_htrans", 64'(bus.dst_htrans), 64'h00);
      tick();
    end
    drive(IDLE, 32'h0, 4'hF, 4'h0, 1'b0); settle_check();
    chk("stall_release", 64'(bus.src_hready_resp), 64'h1);
    tick();

    step(NONSEQ, 32'hA000_0000, 4'hF, 4'h0, 1'b0);
    drive(IDLE, 32'h0, 4'hF, 4'h0, 1'b0);
    rst_n = 1'b0; settle_check(); tick(); rst_n = 1'b1;
    drive(IDLE, 32'h0, 4'hF, 4'h0, 1'b0); settle_check();
    chk("rst_err_rdy", 64'(bus.src_hready_resp), 64'h1);
    chk("rst_err_resp", 64'(bus.src_hresp), 64'h0);
    chk("rst_err_valid", 64'(err_valid), 64'h0);
    tick();

    step(NONSEQ, 32'hC000_0000, 4'hF, 4'h0, 1'b0);
    step(IDLE, 32'h0, 4'hF, 4'h0, 1'b0);
    step(IDLE, 32'h0, 4'hF, 4'h0, 1'b1);
    step(NONSEQ, 32'hA000_0004, 4'hF, 4'h0, 1'b0);
    drive(IDLE, 32'h0, 4'hF, 4'h0, 1'b0); settle_check();
`ifdef AHBL_SPLITTER_ERR_CAPTURE_EN
    chk("recap_addr", 64'(err_addr), 64'hA000_0004);
    chk("recap_valid", 64'(err_valid), 64'h1);
`else
    chk("nocap_valid", 64'(err_valid), 64'h0);
`endif
    tick();
    step(IDLE, 32'h0, 4'hF, 4'h0, 1'b0);

    beats = 0; acc = 1'b1; tr = IDLE; a = '0;
    for (int c = 0; c < 1500; c++) begin
      if (acc) begin
        if (beats > 0) begin
          if ($urandom_range(0, 4) == 0) tr = BUSY;
          else begin tr = SEQ; a = a + 32'd4; beats--; end
        end else begin
          r = $urandom_range(0, 9);
          if (r < 2) tr = IDLE;
          else if (r == 2) begin tr = SEQ; a = a + 32'd4; end
          else begin
            tr = NONSEQ;
            r = $urandom_range(0, 5);
            if (r < 4)       a = (32'(r) * 32'h2000_0000) | ($urandom & 32'h1FFF_FFFC);
            else if (r == 4) a = 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
            else             a = 32'h1FFF_FFF8;
            beats = ($urandom_range(0, 1) == 1) ? 3 : 0;
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        rdyv[i]  = ($urandom_range(0, 3) != 0);
        respv[i] = ($urandom_range(0, 15) == 0);
      end
      drive(tr, a, rdyv, respv, $urandom_range(0, 9) == 0);
      settle_check();
      acc = exp_rdy;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
